// File: rtl/seg7_scan_capture.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment scan: filters
// scan transients, decodes glyphs back to hex and reassembles the 16-bit value.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  segment,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  seen,
    output logic        frame_valid,
    output logic [15:0] frame_value,
    output logic        bad_pattern
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [11:0]      sync1_q, s2_q, s2_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accepted_q;

    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_valid_q, frame_valid_d;
    logic [15:0] frame_value_q, frame_value_d;
    logic        bad_q, bad_d;

    logic       same, accept, one_low, glyph_ok, hit;
    logic [1:0] sel;
    logic [3:0] nibble;

    // Active-high gfedcba pattern to hex nibble; bit 4 flags a legal glyph.
    function automatic logic [4:0] glyph_to_nibble(input logic [6:0] g);
        case (g)
            7'h3F: return 5'h10;
            7'h06: return 5'h11;
            7'h5B: return 5'h12;
            7'h4F: return 5'h13;
            7'h66: return 5'h14;
            7'h6D: return 5'h15;
            7'h7D: return 5'h16;
            7'h07: return 5'h17;
            7'h7F: return 5'h18;
            7'h6F: return 5'h19;
            7'h77: return 5'h1A;
            7'h7C: return 5'h1B;
            7'h39: return 5'h1C;
            7'h5E: return 5'h1D;
            7'h79: return 5'h1E;
            7'h71: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    assign same   = (s2_q == s2_prev_q);
    assign accept = same && (cnt_q == CNT_MAX) && !accepted_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; async reset sits in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            s2_q       <= '0;
            s2_prev_q  <= '0;
            cnt_q      <= '0;
            accepted_q <= 1'b0;
        end else begin
            sync1_q   <= {an, segment};
            s2_q      <= sync1_q;
            s2_prev_q <= s2_q;
            if (!same) begin
                cnt_q      <= '0;
                accepted_q <= 1'b0;
            end else begin
                if (cnt_q < CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
                if (accept) accepted_q <= 1'b1;
            end
        end
    end

    always_comb begin
        one_low = 1'b1;
        sel     = 2'd0;
        case (s2_q[11:8])
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: one_low = 1'b0;
        endcase
        {glyph_ok, nibble} = glyph_to_nibble(~s2_q[6:0]);
        hit = accept && one_low && glyph_ok;
    end

    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block can infer a latch.
    always_comb begin
        digits_d      = digits_q;
        dp_d          = dp_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
        frame_value_d = frame_value_q;
        bad_d         = bad_q;

        if (hit) begin
            digits_d[{sel, 2'b00} +: 4] = nibble;
            dp_d[sel]                   = ~s2_q[7];
        end
        if (accept && one_low && !glyph_ok) bad_d = 1'b1;

        // clear wins over frame tracking, but the digit/dp update still lands.
        if (clear) begin
            seen_d = 4'h0;
            bad_d  = 1'b0;
        end else if (hit) begin
            seen_d[sel] = 1'b1;
            if (seen_d == 4'hF) begin
                frame_valid_d = 1'b1;
                frame_value_d = digits_d;
                seen_d        = 4'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q      <= '0;
            dp_q          <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_value_q <= '0;
            bad_q         <= 1'b0;
        end else begin
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            frame_value_q <= frame_value_d;
            bad_q         <= bad_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign seen        = seen_q;
    assign frame_valid = frame_valid_q;
    assign frame_value = frame_value_q;
    assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scenarios with literal expectations,
// then random scans, all compared each cycle against a behavioural model.
module tb_seg7_scan_capture;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  segment = 8'hFF;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  seen;
    logic        frame_valid;
    logic [15:0] frame_value;
    logic        bad_pattern;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;

    seg7_scan_capture #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .segment(segment), .clear(clear),
        .digits(digits), .dp(dp), .seen(seen), .frame_valid(frame_valid),
        .frame_value(frame_value), .bad_pattern(bad_pattern)
    );

    always #5 clk = ~clk;

    // Active-high gfedcba glyph for each hex value.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the decoder sees each pin sample two edges late (zeros after reset);
    // a value is taken once it has appeared in STABLE+1 consecutive views.
    logic [11:0] pipe[$];
    logic [11:0] m_prev = '0;
    int          m_run = 1;
    logic [15:0] m_dig = '0, m_fval = '0;
    logic [3:0]  m_dp = '0, m_seen = '0;
    logic        m_fv = 1'b0, m_bad = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.delete();
            pipe.push_back(12'h0);
            pipe.push_back(12'h0);
            m_prev = '0; m_run = 1;
            m_dig = '0; m_fval = '0; m_dp = '0; m_seen = '0; m_fv = 1'b0; m_bad = 1'b0;
        end else begin
            logic [11:0] v;
            int idx, lows, nib;
            v = pipe.pop_front();
            pipe.push_back({an, segment});
            m_run  = (v == m_prev) ? ((m_run > STABLE + 1) ? m_run : m_run + 1) : 1;
            m_prev = v;
            m_fv   = 1'b0;
            lows = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (!v[8+i]) begin lows++; idx = i; end
            if (m_run == STABLE + 1 && lows == 1) begin
                nib = -1;
                for (int g = 0; g < 16; g++) if (glyph[g] == ~v[6:0]) nib = g;
                if (nib < 0) m_bad = 1'b1;
                else begin
                    m_dig[idx*4 +: 4] = nib[3:0];
                    m_dp[idx] = ~v[7];
                    if (!clear) begin
                        m_seen[idx] = 1'b1;
                        if (m_seen == 4'hF) begin
                            m_fv = 1'b1; m_fval = m_dig; m_seen = 4'h0;
                        end
                    end
                end
            end
            if (clear) begin m_seen = 4'h0; m_bad = 1'b0; end
        end
    end

    always @(negedge clk) begin
        check("digits", digits, m_dig);
        check("dp", 16'(dp), 16'(m_dp));
        check("seen", 16'(seen), 16'(m_seen));
        check("frame_valid", 16'(frame_valid), 16'(m_fv));
        check("frame_value", frame_value, m_fval);
        check("bad_pattern", 16'(bad_pattern), 16'(m_bad));
        if (frame_valid === 1'b1) fv_cnt++;
    end

    // Present pins for n samples; clear (if requested) is sampled on the first only.
    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n, input logic c);
        @(posedge clk); #2;
        an = a; segment = s; clear = c;
        for (int i = 0; i < n - 1; i++) begin
            @(posedge clk); #2;
            clear = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #2; clear = 1'b1;
        @(posedge clk); #2; clear = 1'b0;
    endtask

    task automatic scan_1234();
        hold(4'b0111, 8'hF9, 8, 1'b0);
        hold(4'b1011, 8'hA4, 8, 1'b0);
        hold(4'b1101, 8'hB0, 8, 1'b0);
        hold(4'b1110, 8'h99, 8, 1'b0);
        hold(4'hF, 8'hFF, 10, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digits"}, digits, 16'h0);
        check({tag, "_dp"}, 16'(dp), 16'h0);
        check({tag, "_seen"}, 16'(seen), 16'h0);
        check({tag, "_fv"}, 16'(frame_valid), 16'h0);
        check({tag, "_fval"}, frame_value, 16'h0);
        check({tag, "_bad"}, 16'(bad_pattern), 16'h0);
    endtask

    initial begin
        int f0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Latency: first sample at edge k, update at edge k+STABLE+2.
        @(posedge clk); #2; an = 4'b1110; segment = 8'hB0;
        repeat (STABLE + 2) @(posedge clk);
        @(negedge clk) check("lat_early", digits, 16'h0000);
        @(posedge clk);
        @(negedge clk) check("lat_digits", digits, 16'h0003);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_seen", 16'(seen), 16'h0001);
        check("t1_dp", 16'(dp), 16'h0000);
        check("t1_bad", 16'(bad_pattern), 16'h0000);

        // Short hold is discarded, long hold is accepted.
        hold(4'b1101, 8'hF9, 3, 1'b0);
        hold(4'hF, 8'hFF, 12, 1'b0);
        @(negedge clk);
        check("glitch_digits", digits, 16'h0003);
        check("glitch_seen", 16'(seen), 16'h0001);
        hold(4'b1101, 8'hF9, 6, 1'b0);
        hold(4'hF, 8'hFF, 10, 1'b0);
        @(negedge clk);
        check("hold6_digits", digits, 16'h0013);
        check("hold6_seen", 16'(seen), 16'h0003);

        // Full scan.
        pulse_clear();
        f0 = fv_cnt;
        scan_1234();
        @(negedge clk);
        check("scan_pulses", 16'(fv_cnt - f0), 16'h0001);
        check("scan_value", frame_value, 16'h1234);
        check("scan_seen", 16'(seen), 16'h0000);

        // Non-hex glyph.
        hold(4'b0111, 8'hFE, 8, 1'b0);
        hold(4'hF, 8'hFF, 10, 1'b0);
        @(negedge clk);
        check("err_bad", 16'(bad_pattern), 16'h0001);
        check("err_digit3", 16'(digits[15:12]), 16'h0001);
        pulse_clear();
        @(negedge clk) check("err_cleared", 16'(bad_pattern), 16'h0000);

        // Two anodes low is ignored; then digit 2 = 0 with dp on.
        hold(4'b1100, 8'hC0, 8, 1'b0);
        hold(4'hF, 8'hFF, 10, 1'b0);
        @(negedge clk);
        check("ill_digits", digits, 16'h1234);
        check("ill_bad", 16'(bad_pattern), 16'h0000);
        hold(4'b1011, 8'h40, 8, 1'b0);
        hold(4'hF, 8'hFF, 10, 1'b0);
        @(negedge clk);
        check("dp_digit2", 16'(digits[11:8]), 16'h0000);
        check("dp_bit2", 16'(dp[2]), 16'h0001);

        // Async reset mid-frame, then a clean frame.
        pulse_clear();
        hold(4'b0111, 8'hF9, 8, 1'b0);
        hold(4'b1011, 8'hA4, 8, 1'b0);
        @(negedge clk) check("mid_seen", 16'(seen), 16'h000C);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async");
        an = 4'hF; segment = 8'hFF;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        f0 = fv_cnt;
        scan_1234();
        @(negedge clk);
        check("post_rst_pulses", 16'(fv_cnt - f0), 16'h0001);
        check("post_rst_value", frame_value, 16'h1234);

        // Random scans.
        for (int it = 0; it < 300; it++) begin
            logic [3:0] a;
            logic [7:0] s;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) a = 4'hF;
            else             a = 4'($urandom);
            if ($urandom_range(0, 7) == 0) s = 8'($urandom);
            else s = ~{1'($urandom), glyph[$urandom_range(0, 15)]};
            hold(a, s, $urandom_range(1, 9), ($urandom_range(0, 11) == 0));
        end
        hold(4'hF, 8'hFF, 10, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
Receive-side decoder for the board's multiplexed 4-digit seven-segment interface (AN/SEGMENT), the opposite end of the display scan driver. It samples the scanned anode and segment lines and filters scan transients. It decodes each segment glyph back to a hex nibble and reassembles the 16-bit displayed value. It is used as an on-chip loopback checker for the display path and as a self-checking monitor in top-level benches.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronized samples of {an,segment} needed to accept a digit (legal range 2..255).
CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES-1.

Ports:
clk  input  1  system clock (all logic on rising edge).
rst_n  input  1  asynchronous active-low reset.
an  input  4  anode selects, active-low; an[i]=0 selects digit i (digit 3 is leftmost/most significant).
segment  input  8  segment lines, active-low, order {dp,g,f,e,d,c,b,a}.
clear  input  1  synchronous clear of frame tracking and error flag.
digits  output  16  live decoded nibbles; digits[4i+3:4i] belongs to digit i.
dp  output  4  live decimal-point state, active-high; dp[i] belongs to digit i.
seen  output  4  digits accepted since the last frame completion.
frame_valid  output  1  one-cycle pulse when all four digits have been accepted.
frame_value  output  16  snapshot of digits, loaded on frame_valid.
bad_pattern  output  1  sticky flag: an accepted sample carried a non-hex glyph.

Behaviour:
- Reset (rst_n=0, async): all outputs are 0. Synchronizer flops, stability counter, and the accepted flag are cleared.
- Input sync: the 12-bit {an,segment} passes through a 2-flop synchronizer. The second stage is s2; its previous value is s2_prev.
- Stability filter:
  - if s2 != s2_prev: cnt<=0, accepted<=0.
  - else if cnt < STABLE_CYCLES-1: cnt<=cnt+1.
  - An accept strobe fires exactly once per hold, when s2 has been identical for STABLE_CYCLES consecutive samples and accepted=0. The strobe then sets accepted=1.
- Latency: pins stable from edge k means outputs update at edge k+STABLE_CYCLES+2. A hold shorter than STABLE_CYCLES synchronized samples is discarded silently.
- On the accept strobe:
  - an not exactly one-low (4'hF blank, or two or more low): ignored. No update, no error.
  - Exactly one low bit i: decode ~segment[6:0] (gfedcba, active-high) using this table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Match: digits[4i+3:4i]<=nibble, dp[i]<=~segment[7], seen[i]<=1.
  - No match: bad_pattern<=1. Digit i, dp and seen are unchanged.
- Frame completion: if the accept makes seen==4'hF, then in the same edge frame_valid<=1, frame_value<={updated digits}, and seen<=0. frame_valid is high for one cycle only.
- Re-accepting an already-seen digit overwrites digits/dp and leaves seen unchanged. Repeated glyphs are allowed.
- clear=1: seen<=0 and bad_pattern<=0. digits, dp and frame_value are retained. clear has priority over any accept or frame completion in the same cycle: no frame_valid, and no seen update on that edge (digits/dp still update).
- Reset mid-frame: all state returns to reset values immediately. Capture restarts from an empty frame.

Test Plan:
- Reset, then an=4'b1110, segment=8'hB0 (glyph 3, dp off) held 10 cycles -> digits=16'h0003, seen=4'b0001, dp=0, bad_pattern=0. Update occurs at edge STABLE_CYCLES+2 after the input change.
- Glitch: an=4'b1101, segment=8'hF9 held 3 cycles, then an=4'hF -> no change to digits or seen. Same stimulus held 6 cycles -> digits[7:4]=1.
- Full scan: drive digits 3..0 = glyphs 1,2,3,4 (segment 8'hF9, 8'hA4, 8'hB0, 8'h99), 8 cycles each -> single frame_valid pulse, frame_value=16'h1234, seen=0 afterwards.
- Error: an=4'b0111, segment=8'hFE (only 'a' lit) held 8 cycles -> bad_pattern=1, digits[15:12] unchanged. Then clear for 1 cycle -> bad_pattern=0.
- Illegal anode: an=4'b1100, segment=8'hC0 held 8 cycles -> no update, no error. Then an=4'b1011, segment=8'h40 -> digits[11:8]=0, dp[2]=1.
- Asynchronous reset asserted after two digits of a frame -> all outputs 0 without a clock edge. The next four-digit scan produces exactly one frame_valid.
